multi_servo_pwm: RTL

- NUM_CH-channel servo PWM generator with programmable pulse widths; successor to the single-channel switch-driven servo PWM block.
- Each channel has a position register loaded through a valid/ready write port. The value takes effect only at a frame boundary, so no pulse is ever glitched.
- One frame counter is shared by all channels, so every channel's pulse starts in the same cycle.
- Sits between the game/control logic (paddle position) and the servo output pins.

---
 rtl/multi_servo_pwm_if.sv | 14 +
 rtl/multi_servo_pwm.sv | 114 +++++++++++
 2 files changed

// File: rtl/multi_servo_pwm_if.sv
// Position write channel (valid/ready) into multi_servo_pwm.
// The slave side belongs to the PWM block; the master side to control logic.
interface multi_servo_pwm_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned POS_W = 8
);
  logic             pos_valid;
  logic             pos_ready;
  logic [CH_W-1:0]  pos_ch;
  logic [POS_W-1:0] pos_data;

  modport master (output pos_valid, output pos_ch, output pos_data, input pos_ready);
  modport slave  (input pos_valid, input pos_ch, input pos_data, output pos_ready);
endinterface

// File: rtl/multi_servo_pwm.sv
// NUM_CH servo PWM channels on one shared frame counter; new positions commit at the
// frame boundary. Define SLEW_LIMIT_EN to limit position change to SLEW_STEP per frame.
module multi_servo_pwm #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned POS_W     = 8,
  parameter int unsigned FRAME_CYC = 1000000,
  parameter int unsigned MIN_CYC   = 50000,
  parameter int unsigned STEP_CYC  = 196,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  multi_servo_pwm_if.slave  pos,
  input  logic [NUM_CH-1:0] out_en,
  output logic              pos_err,
  output logic              frame_start,
  output logic [NUM_CH-1:0] pwm
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  target_q [NUM_CH];
  logic [POS_W-1:0]  target_d [NUM_CH];
  logic [POS_W-1:0]  active_q [NUM_CH];
  logic [POS_W-1:0]  active_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              fs_q, fs_d;
  logic              commit;
  logic              wr_fire;
  logic              ch_ok;
  logic [CH_W-1:0]   wr_ch;

  always_comb begin
    commit   = (cnt_q == CNT_LAST);
    cnt_d    = commit ? '0 : cnt_q + 1'b1;
    wr_ch    = pos.pos_ch;
    wr_fire  = pos.pos_valid && ready_q;
    ch_ok    = (32'(wr_ch) < NUM_CH);
    err_d    = wr_fire && !ch_ok;
    ready_d  = (cnt_d != CNT_LAST);
    fs_d     = (cnt_d == '0);
    target_d = target_q;
    active_d = active_q;
    en_d     = en_q;
    pwm_d    = '0;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_fire && (wr_ch == CH_W'(i))) begin
        target_d[i] = pos.pos_data;
      end
    end

    if (commit) begin
      en_d = out_en;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef SLEW_LIMIT_EN
        // Step is only applied when the gap exceeds it, so no overshoot or wrap.
        if (target_q[i] > active_q[i]) begin
          if (32'(target_q[i] - active_q[i]) > SLEW_STEP) begin
            active_d[i] = active_q[i] + POS_W'(SLEW_STEP);
          end else begin
            active_d[i] = target_q[i];
          end
        end else if (target_q[i] < active_q[i]) begin
          if (32'(active_q[i] - target_q[i]) > SLEW_STEP) begin
            active_d[i] = active_q[i] - POS_W'(SLEW_STEP);
          end else begin
            active_d[i] = target_q[i];
          end
        end
`else
        active_d[i] = target_q[i];
`endif
      end
    end

    // Outputs are decoded from next-state values so the registers line up with cnt_q.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en_d[i] && (32'(cnt_d) < (MIN_CYC + 32'(active_d[i]) * STEP_CYC));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      cnt_q    <= CNT_LAST;
      target_q <= '{default: '0};
      active_q <= '{default: '0};
      en_q     <= '0;
      pwm_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
      active_q <= active_d;
      en_q     <= en_d;
      pwm_q    <= pwm_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      fs_q     <= fs_d;
    end
  end

  assign pos.pos_ready = ready_q;
  assign pos_err       = err_q;
  assign frame_start   = fs_q;
  assign pwm           = pwm_q;
endmodule
